// File: rtl/tlbread_front_if.sv
// Request/response bundle between the read splitter (tlbread_*) and the TLB core (tlb_*).
// slave: the conditioning stage; master: the splitter plus TLB environment around it.
interface tlbread_front_if;
    logic        tlbread_do;
    logic [1:0]  tlbread_cpl;
    logic [31:0] tlbread_address;
    logic [3:0]  tlbread_length;
    logic [3:0]  tlbread_length_full;
    logic        tlbread_lock;
    logic        tlbread_rmw;
    logic        tlbread_done;
    logic        tlbread_page_fault;
    logic        tlbread_ac_fault;
    logic        tlbread_retry;
    logic [63:0] tlbread_data;

    logic        tlb_do;
    logic [1:0]  tlb_cpl;
    logic [31:0] tlb_address;
    logic [3:0]  tlb_length;
    logic        tlb_lock;
    logic        tlb_rmw;
    logic        tlb_done;
    logic        tlb_page_fault;
    logic        tlb_retry;
    logic [63:0] tlb_data;

    modport slave (
        input  tlbread_do, tlbread_cpl, tlbread_address, tlbread_length,
               tlbread_length_full, tlbread_lock, tlbread_rmw,
        output tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry, tlbread_data,
        output tlb_do, tlb_cpl, tlb_address, tlb_length, tlb_lock, tlb_rmw,
        input  tlb_done, tlb_page_fault, tlb_retry, tlb_data
    );

    modport master (
        output tlbread_do, tlbread_cpl, tlbread_address, tlbread_length,
               tlbread_length_full, tlbread_lock, tlbread_rmw,
        input  tlbread_done, tlbread_page_fault, tlbread_ac_fault, tlbread_retry, tlbread_data,
        input  tlb_do, tlb_cpl, tlb_address, tlb_length, tlb_lock, tlb_rmw,
        output tlb_done, tlb_page_fault, tlb_retry, tlb_data
    );
endinterface

// File: rtl/tlbread_front.sv
// Read request conditioning ahead of the TLB: #AC alignment check, retry re-issue, response pulses.
// Optional retry-limit monitor enabled by defining TLBREAD_FRONT_RETRY_LIMIT_EN.
module tlbread_front #(
    parameter int unsigned RETRY_GAP   = 2,
    parameter int unsigned RETRY_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ac_check_en,
    tlbread_front_if.slave   bus,
    output logic             retry_overflow
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} state_t;

    typedef struct packed {
        logic [1:0]  cpl;
        logic [31:0] address;
        logic [3:0]  length;
        logic        lock;
        logic        rmw;
    } req_t;

    state_t             state, next_state;
    req_t               req_q;
    logic               ac_pend_q;
    logic               abandon_q;
    logic [CNT_W-1:0]   gap_cnt;
    logic [63:0]        data_q;
    logic               tlb_do_q, done_q, pf_q, ac_q, retry_q;

    logic lat_req, ac_set, pf_set, done_set, retry_set, gap_load, abandon_set;
    logic discard, misalign, tlb_do_d;

    // Alignment is judged on the whole access, only for user-mode with AM/AC enabled
    always_comb begin
        misalign = ac_check_en && (bus.tlbread_cpl == 2'd3) &&
                   (((bus.tlbread_length_full == 4'd2) && bus.tlbread_address[0]) ||
                    ((bus.tlbread_length_full == 4'd4) && (bus.tlbread_address[1:0] != 2'd0)) ||
                    ((bus.tlbread_length_full == 4'd8) && (bus.tlbread_address[2:0] != 3'd0)));
    end

    // Next state and per-cycle actions; a dropped upstream request turns any response into a discard
    always_comb begin
        next_state  = state;
        lat_req     = 1'b0;
        ac_set      = 1'b0;
        pf_set      = 1'b0;
        done_set    = 1'b0;
        retry_set   = 1'b0;
        gap_load    = 1'b0;
        abandon_set = 1'b0;
        discard     = abandon_q || !bus.tlbread_do;
        unique case (state)
            IDLE: begin
                if (bus.tlbread_do) begin
                    lat_req    = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (ac_pend_q) begin
                    ac_set     = !discard;
                    next_state = discard ? IDLE : RESP;
                end else if (bus.tlb_page_fault) begin
                    pf_set     = !discard;
                    next_state = discard ? IDLE : RESP;
                end else if (bus.tlb_done) begin
                    done_set   = !discard;
                    next_state = discard ? IDLE : RESP;
                end else if (bus.tlb_retry) begin
                    if (discard) begin
                        next_state = IDLE;
                    end else begin
                        retry_set  = 1'b1;
                        gap_load   = 1'b1;
                        next_state = GAP;
                    end
                end else if (!bus.tlbread_do) begin
                    abandon_set = 1'b1;
                end
            end
            GAP: begin
                if (!bus.tlbread_do) begin
                    next_state = IDLE;
                end else if (gap_cnt <= CNT_W'(1)) begin
                    next_state = ISSUE;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // A misaligned request still spends one ISSUE cycle, but the TLB never sees it
        tlb_do_d = (next_state == ISSUE) && !(lat_req && misalign);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= '0;
            ac_pend_q <= 1'b0;
            abandon_q <= 1'b0;
            gap_cnt   <= '0;
            data_q    <= '0;
            tlb_do_q  <= 1'b0;
            done_q    <= 1'b0;
            pf_q      <= 1'b0;
            ac_q      <= 1'b0;
            retry_q   <= 1'b0;
        end else begin
            state    <= next_state;
            tlb_do_q <= tlb_do_d;
            done_q   <= done_set;
            pf_q     <= pf_set;
            ac_q     <= ac_set;
            retry_q  <= retry_set;
            if (lat_req) begin
                req_q     <= '{cpl:     bus.tlbread_cpl,
                               address: bus.tlbread_address,
                               length:  bus.tlbread_length,
                               lock:    bus.tlbread_lock,
                               rmw:     bus.tlbread_rmw};
                ac_pend_q <= misalign;
            end
            if (lat_req || (next_state == IDLE)) begin
                abandon_q <= 1'b0;
            end else if (abandon_set) begin
                abandon_q <= 1'b1;
            end
            if (done_set) begin
                data_q <= bus.tlb_data;
            end
            if (gap_load) begin
                gap_cnt <= CNT_W'(RETRY_GAP);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - CNT_W'(1);
            end
        end
    end

`ifdef TLBREAD_FRONT_RETRY_LIMIT_EN
    logic [CNT_W-1:0] retry_cnt;
    logic             overflow_q;

    // Per-request saturating retry count; the overflow flag outlives the request
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (next_state == IDLE) begin
                retry_cnt <= '0;
            end else if (retry_set && (retry_cnt != CNT_W'(RETRY_LIMIT))) begin
                retry_cnt <= retry_cnt + CNT_W'(1);
            end
            if (retry_set && (({1'b0, retry_cnt} + 5'd1) >= 5'(RETRY_LIMIT))) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign retry_overflow = overflow_q;
`else
    logic unused_retry_limit;
    assign unused_retry_limit = ^CNT_W'(RETRY_LIMIT);
    assign retry_overflow     = 1'b0;
`endif

    assign bus.tlb_do             = tlb_do_q;
    assign bus.tlb_cpl            = req_q.cpl;
    assign bus.tlb_address        = req_q.address;
    assign bus.tlb_length         = req_q.length;
    assign bus.tlb_lock           = req_q.lock;
    assign bus.tlb_rmw            = req_q.rmw;
    assign bus.tlbread_done       = done_q;
    assign bus.tlbread_page_fault = pf_q;
    assign bus.tlbread_ac_fault   = ac_q;
    assign bus.tlbread_retry      = retry_q;
    assign bus.tlbread_data       = data_q;

endmodule

// File: tb/tb_tlbread_front.sv
// Directed bench for tlbread_front: response scoreboard plus cycle-exact checks on the TLB side.
// Retry-limit section runs only when TLBREAD_FRONT_RETRY_LIMIT_EN is defined.
module tb_tlbread_front;

    localparam logic [1:0] K_DONE = 2'd0;
    localparam logic [1:0] K_PF   = 2'd1;
    localparam logic [1:0] K_AC   = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic ac_check_en;
    logic retry_overflow;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    tlbread_front_if bus ();

    tlbread_front #(.RETRY_GAP(2), .RETRY_LIMIT(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .ac_check_en    (ac_check_en),
        .bus            (bus),
        .retry_overflow (retry_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_resp(input logic [1:0] k, input logic [63:0] d);
        exp_q.push_back('{kind: k, data: d});
    endtask

    // Any done/fault pulse must match the oldest expected response
    task automatic scoreboard();
        exp_t        e;
        int          n;
        logic [1:0]  k;
        n = int'(bus.tlbread_done) + int'(bus.tlbread_page_fault) + int'(bus.tlbread_ac_fault);
        if (!rst && (n != 0)) begin
            k = bus.tlbread_done ? K_DONE : (bus.tlbread_page_fault ? K_PF : K_AC);
            check("resp_onehot", 64'(n), 64'd1);
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("resp_kind", 64'(k), 64'(e.kind));
                if (e.kind == K_DONE) check("resp_data", bus.tlbread_data, e.data);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        scoreboard();
    endtask

    task automatic request(input logic [31:0] a, input logic [1:0] cpl, input logic [3:0] len);
        bus.tlbread_do          = 1'b1;
        bus.tlbread_address     = a;
        bus.tlbread_cpl         = cpl;
        bus.tlbread_length      = len;
        bus.tlbread_length_full = len;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        failures = 0;
        ac_check_en = 1'b1;
        bus.tlbread_do = 1'b0;
        bus.tlbread_cpl = 2'd0;
        bus.tlbread_address = 32'h0;
        bus.tlbread_length = 4'd0;
        bus.tlbread_length_full = 4'd0;
        bus.tlbread_lock = 1'b0;
        bus.tlbread_rmw = 1'b0;
        bus.tlb_done = 1'b0;
        bus.tlb_page_fault = 1'b0;
        bus.tlb_retry = 1'b0;
        bus.tlb_data = 64'h0;

        step(); step();
        check("rst_tlb_do", 64'(bus.tlb_do), 64'd0);
        check("rst_done", 64'(bus.tlbread_done), 64'd0);
        check("rst_retry", 64'(bus.tlbread_retry), 64'd0);
        check("rst_data", bus.tlbread_data, 64'h0);
        check("rst_overflow", 64'(retry_overflow), 64'd0);
        rst = 1'b0;
        step();

        // Aligned read, TLB answers in the issue cycle
        request(32'h1000, 2'd3, 4'd4);
        expect_resp(K_DONE, 64'h1122334455667788);
        step();
        check("t1_tlb_do", 64'(bus.tlb_do), 64'd1);
        check("t1_tlb_addr", 64'(bus.tlb_address), 64'h1000);
        check("t1_tlb_cpl", 64'(bus.tlb_cpl), 64'd3);
        check("t1_tlb_len", 64'(bus.tlb_length), 64'd4);
        check("t1_done_early", 64'(bus.tlbread_done), 64'd0);
        bus.tlb_done = 1'b1;
        bus.tlb_data = 64'h1122334455667788;
        step();
        check("t1_done", 64'(bus.tlbread_done), 64'd1);
        check("t1_data", bus.tlbread_data, 64'h1122334455667788);
        check("t1_tlb_do_resp", 64'(bus.tlb_do), 64'd0);
        bus.tlb_done = 1'b0;
        step();
        check("t1_stale_ignored", 64'(bus.tlb_do), 64'd0);
        check("t1_done_single", 64'(bus.tlbread_done), 64'd0);
        bus.tlbread_do = 1'b0;
        step();

        // Misaligned user-mode dword: #AC, TLB untouched
        request(32'h1002, 2'd3, 4'd4);
        expect_resp(K_AC, 64'h0);
        step();
        check("t2_tlb_do_a", 64'(bus.tlb_do), 64'd0);
        check("t2_ac_early", 64'(bus.tlbread_ac_fault), 64'd0);
        step();
        check("t2_ac", 64'(bus.tlbread_ac_fault), 64'd1);
        check("t2_tlb_do_b", 64'(bus.tlb_do), 64'd0);
        step();
        check("t2_ac_single", 64'(bus.tlbread_ac_fault), 64'd0);
        check("t2_tlb_do_c", 64'(bus.tlb_do), 64'd0);
        bus.tlbread_do = 1'b0;
        step();

        // Same address at cpl 0 is issued normally
        request(32'h1002, 2'd0, 4'd4);
        expect_resp(K_DONE, 64'h0a0b0c0d0e0f1011);
        step();
        check("t2k_tlb_do", 64'(bus.tlb_do), 64'd1);
        check("t2k_tlb_addr", 64'(bus.tlb_address), 64'h1002);
        bus.tlb_done = 1'b1;
        bus.tlb_data = 64'h0a0b0c0d0e0f1011;
        step();
        check("t2k_done", 64'(bus.tlbread_done), 64'd1);
        bus.tlb_done = 1'b0;
        step();
        bus.tlbread_do = 1'b0;
        step();

        // Two retries, gap of exactly two cycles each
        request(32'h3000, 2'd3, 4'd8);
        expect_resp(K_DONE, 64'hcafef00d12345678);
        step();
        check("t3_issue0", 64'(bus.tlb_do), 64'd1);
        for (int r = 0; r < 2; r++) begin
            bus.tlb_retry = 1'b1;
            step();
            check("t3_gap1_do", 64'(bus.tlb_do), 64'd0);
            check("t3_retry_pulse", 64'(bus.tlbread_retry), 64'd1);
            bus.tlb_retry = 1'b0;
            step();
            check("t3_gap2_do", 64'(bus.tlb_do), 64'd0);
            check("t3_retry_single", 64'(bus.tlbread_retry), 64'd0);
            step();
            check("t3_reissue", 64'(bus.tlb_do), 64'd1);
            check("t3_addr_kept", 64'(bus.tlb_address), 64'h3000);
        end
        bus.tlb_done = 1'b1;
        bus.tlb_data = 64'hcafef00d12345678;
        step();
        check("t3_done", 64'(bus.tlbread_done), 64'd1);
        check("t3_overflow_low", 64'(retry_overflow), 64'd0);
        bus.tlb_done = 1'b0;
        step();
        bus.tlbread_do = 1'b0;
        step();

        // Fault beats done; data register keeps the previous read
        request(32'h4000, 2'd3, 4'd4);
        expect_resp(K_PF, 64'h0);
        step();
        bus.tlb_page_fault = 1'b1;
        bus.tlb_done = 1'b1;
        bus.tlb_data = 64'hdeadbeefdeadbeef;
        step();
        check("t4_pf", 64'(bus.tlbread_page_fault), 64'd1);
        check("t4_no_done", 64'(bus.tlbread_done), 64'd0);
        check("t4_data_kept", bus.tlbread_data, 64'hcafef00d12345678);
        bus.tlb_page_fault = 1'b0;
        bus.tlb_done = 1'b0;
        step();
        bus.tlbread_do = 1'b0;
        step();

        // Request withdrawn during the gap, then a fresh one right away
        request(32'h5000, 2'd3, 4'd4);
        step();
        bus.tlb_retry = 1'b1;
        step();
        check("t5_retry_pulse", 64'(bus.tlbread_retry), 64'd1);
        bus.tlb_retry = 1'b0;
        bus.tlbread_do = 1'b0;
        step();
        check("t5_idle_do", 64'(bus.tlb_do), 64'd0);
        request(32'h2000, 2'd3, 4'd4);
        expect_resp(K_DONE, 64'h5555aaaa5555aaaa);
        step();
        check("t5_new_issue", 64'(bus.tlb_do), 64'd1);
        check("t5_new_addr", 64'(bus.tlb_address), 64'h2000);
        bus.tlb_done = 1'b1;
        bus.tlb_data = 64'h5555aaaa5555aaaa;
        step();
        check("t5_done", 64'(bus.tlbread_done), 64'd1);
        bus.tlb_done = 1'b0;
        step();
        bus.tlbread_do = 1'b0;
        step();

        // Request withdrawn while issued: TLB answer is swallowed
        request(32'h7000, 2'd3, 4'd4);
        step();
        bus.tlbread_do = 1'b0;
        step();
        check("t6_do_held", 64'(bus.tlb_do), 64'd1);
        bus.tlb_done = 1'b1;
        bus.tlb_data = 64'h1;
        step();
        check("t6_no_pulse", 64'(bus.tlbread_done), 64'd0);
        check("t6_tlb_do_drop", 64'(bus.tlb_do), 64'd0);
        check("t6_data_kept", bus.tlbread_data, 64'h5555aaaa5555aaaa);
        bus.tlb_done = 1'b0;
        step();

`ifdef TLBREAD_FRONT_RETRY_LIMIT_EN
        request(32'h6000, 2'd0, 4'd4);
        expect_resp(K_DONE, 64'h6666);
        step();
        for (int r = 0; r < 4; r++) begin
            bus.tlb_retry = 1'b1;
            step();
            check("t7_retry_pulse", 64'(bus.tlbread_retry), 64'd1);
            check("t7_overflow", 64'(retry_overflow), 64'(r >= 2));
            bus.tlb_retry = 1'b0;
            step();
            step();
            check("t7_reissue", 64'(bus.tlb_do), 64'd1);
        end
        bus.tlb_done = 1'b1;
        bus.tlb_data = 64'h6666;
        step();
        check("t7_done", 64'(bus.tlbread_done), 64'd1);
        check("t7_overflow_done", 64'(retry_overflow), 64'd1);
        bus.tlb_done = 1'b0;
        step();
        bus.tlbread_do = 1'b0;
        step();
        check("t7_overflow_sticky", 64'(retry_overflow), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t7_overflow_rst", 64'(retry_overflow), 64'd0);
        step();
`endif

        // Reset in the middle of an issue
        request(32'h8000, 2'd3, 4'd4);
        step();
        check("t8_issue", 64'(bus.tlb_do), 64'd1);
        rst = 1'b1;
        step();
        check("t8_rst_do", 64'(bus.tlb_do), 64'd0);
        check("t8_rst_data", bus.tlbread_data, 64'h0);
        rst = 1'b0;
        bus.tlbread_do = 1'b0;
        step();
        check("t8_idle", 64'(bus.tlb_do), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
